// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: transmitter state encoding, default timing and command codes.
// Also intended for the keyboard receive path.
package ps2_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } ps2_tx_state_t;

    localparam int DEF_INHIBIT_CYCLES = 6000;     // 120 us at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES = 750000;   // 15 ms at 50 MHz
    localparam int DEF_SYNC_STAGES    = 2;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// N-stage synchronizer for the PS/2 clock and data pins plus a registered
// falling-edge strobe on the synchronized clock.
module ps2_line_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_s,
    output logic o_dat_s,
    output logic o_fall
);

    logic [STAGES-1:0] r_clk_sh;
    logic [STAGES-1:0] r_dat_sh;
    logic              r_clk_d;
    logic              r_fall;

    // Idle bus level is high, so reset to 1 to avoid a spurious fall on exit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_sh <= '1;
            r_dat_sh <= '1;
            r_clk_d  <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_clk_sh[0] <= i_ps2_clk;
            r_dat_sh[0] <= i_ps2_dat;
            for (int i = 1; i < STAGES; i++) begin
                r_clk_sh[i] <= r_clk_sh[i-1];
                r_dat_sh[i] <= r_dat_sh[i-1];
            end
            r_clk_d <= r_clk_sh[STAGES-1];
            r_fall  <= r_clk_d & ~r_clk_sh[STAGES-1];
        end
    end

    assign o_clk_s = r_clk_sh[STAGES-1];
    assign o_dat_s = r_dat_sh[STAGES-1];
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out one byte
// on device clock falls, check the device ACK, then wait for the bus to go idle.
import ps2_defs::*;

module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam logic [31:0] LP_TIMEOUT  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] LP_INH_LAST = 32'(INHIBIT_CYCLES - 1);

    ps2_tx_state_t r_state;
    logic [31:0]   r_cnt;
    logic [3:0]    r_bit_idx;
    logic [7:0]    r_data;
    logic          r_parity;
    logic          r_clk_oe;
    logic          r_dat_oe;
    logic          r_done;
    logic          r_error;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fall;

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk     (CLOCK_50),
        .i_rst_n   (reset),
        .i_ps2_clk (ps2_clk_in),
        .i_ps2_dat (ps2_dat_in),
        .o_clk_s   (w_clk_s),
        .o_dat_s   (w_dat_s),
        .o_fall    (w_fall)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (cmd_valid) begin
                        r_data   <= cmd_data;
                        r_parity <= odd_parity(cmd_data);
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_cnt == LP_INH_LAST - 32'd1)
                        r_dat_oe <= 1'b1;
                    if (r_cnt == LP_INH_LAST) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_cnt    <= LP_TIMEOUT;
                        r_state  <= ST_START;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 32'd1;
                    if (r_state == ST_WAIT_IDLE && w_clk_s && w_dat_s) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_fall) begin
                        r_cnt <= LP_TIMEOUT;
                        case (r_state)
                            ST_START: begin
                                r_dat_oe  <= ~r_data[0];
                                r_bit_idx <= 4'd1;
                                r_state   <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (r_bit_idx == 4'd8) begin
                                    r_dat_oe <= ~r_parity;
                                    r_state  <= ST_PARITY;
                                end else begin
                                    r_dat_oe  <= ~r_data[r_bit_idx[2:0]];
                                    r_bit_idx <= r_bit_idx + 4'd1;
                                end
                            end
                            ST_PARITY: begin
                                r_dat_oe <= 1'b0;
                                r_state  <= ST_ACK;
                            end
                            ST_ACK: begin
                                if (w_dat_s) begin
                                    r_error <= 1'b1;
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_state <= ST_WAIT_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end else if (r_cnt <= 32'd1) begin
                        // Counter hits zero this cycle: abandon the frame and free the bus.
                        r_error  <= 1'b1;
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule
